// File: rtl/tx_specified_len_gen.sv
`default_nettype none
// ============================================================================
// Module   : tx_specified_len_gen
// Brief    : Collects a 4-byte little-endian length/mode command from an
//            8-bit AXI-stream and emits LEN bytes of a test pattern on a
//            (8<<O_EW)-bit AXI-stream with tkeep/tlast.
// Revision : 1.0 - initial release
// ============================================================================
module tx_specified_len_gen #(
    parameter int O_EW   = 2,
    parameter int PKT_EW = 12
) (
    input  logic                     rstn,
    input  logic                     clk,
    output logic                     i_tready,
    input  logic                     i_tvalid,
    input  logic [7:0]               i_tdata,
    input  logic                     o_tready,
    output logic                     o_tvalid,
    output logic [(8<<O_EW)-1:0]     o_tdata,
    output logic [(1<<O_EW)-1:0]     o_tkeep,
    output logic                     o_tlast,
    output logic                     o_busy,
    output logic [15:0]              o_done_cnt
);

    localparam int         c_NB      = 1 << O_EW;
    localparam logic [0:0] c_ST_RECV = 1'b0;
    localparam logic [0:0] c_ST_SEND = 1'b1;

    logic [0:0]  state_q,    state_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [23:0] cmd_lo_q,   cmd_lo_d;
    logic [29:0] len_q,      len_d;
    logic [1:0]  mode_q,     mode_d;
    logic [29:0] k_q,        k_d;
    logic [15:0] done_cnt_q, done_cnt_d;

    logic        w_in_hs;
    logic        w_out_hs;
    logic [29:0] w_len_new;
    logic [30:0] w_k_end;
    logic        w_final_beat;
    logic        w_pkt_bnd;

    assign w_in_hs      = i_tvalid & i_tready;
    assign w_out_hs     = o_tvalid & o_tready;
    assign w_len_new    = {i_tdata[5:0], cmd_lo_q};
    // One past the highest byte index carried by the current beat.
    assign w_k_end      = {1'b0, k_q} + 31'(c_NB);
    assign w_final_beat = (w_k_end >= {1'b0, len_q});

    // Beats are NB-aligned and NB divides 2^PKT_EW, so a packet boundary
    // byte sits in this beat exactly when the beat ends on the boundary.
    generate
        if (PKT_EW == 0) begin : g_pkt_all
            assign w_pkt_bnd = 1'b1;
        end else if (PKT_EW <= 30) begin : g_pkt_mod
            assign w_pkt_bnd = (w_k_end[PKT_EW-1:0] == '0);
        end else begin : g_pkt_none
            assign w_pkt_bnd = 1'b0;
        end
    endgenerate

    function automatic logic [7:0] pattern_byte(input logic [1:0] mode,
                                                input logic [7:0] n);
        case (mode)
            2'b00:   pattern_byte = n;
            2'b01:   pattern_byte = 8'h00;
            2'b10:   pattern_byte = 8'hFF;
            default: pattern_byte = n[0] ? 8'hAA : 8'h55;
        endcase
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= c_ST_RECV;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: leave RECV on a non-empty command, return after final beat.
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_RECV: begin
                if (w_in_hs && (byte_idx_q == 2'd3) && (w_len_new != '0)) begin
                    state_d = c_ST_SEND;
                end
            end
            default: begin
                if (w_out_hs && w_final_beat) begin
                    state_d = c_ST_RECV;
                end
            end
        endcase
    end

    // Datapath registers: command assembly, byte counter, completion count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            byte_idx_q <= '0;
            cmd_lo_q   <= '0;
            len_q      <= '0;
            mode_q     <= '0;
            k_q        <= '0;
            done_cnt_q <= '0;
        end else begin
            byte_idx_q <= byte_idx_d;
            cmd_lo_q   <= cmd_lo_d;
            len_q      <= len_d;
            mode_q     <= mode_d;
            k_q        <= k_d;
            done_cnt_q <= done_cnt_d;
        end
    end

    // Datapath next values; byte_idx wraps 3->0 on the fourth command byte.
    always_comb begin
        byte_idx_d = byte_idx_q;
        cmd_lo_d   = cmd_lo_q;
        len_d      = len_q;
        mode_d     = mode_q;
        k_d        = k_q;
        done_cnt_d = done_cnt_q;
        if (w_in_hs) begin
            byte_idx_d = byte_idx_q + 2'd1;
            case (byte_idx_q)
                2'd0: cmd_lo_d[7:0]   = i_tdata;
                2'd1: cmd_lo_d[15:8]  = i_tdata;
                2'd2: cmd_lo_d[23:16] = i_tdata;
                default: begin
                    len_d  = w_len_new;
                    mode_d = i_tdata[7:6];
                    k_d    = '0;
                    if (w_len_new == '0) begin
                        done_cnt_d = done_cnt_q + 16'd1;
                    end
                end
            endcase
        end
        if (w_out_hs) begin
            k_d = w_k_end[29:0];
            if (w_final_beat) begin
                done_cnt_d = done_cnt_q + 16'd1;
            end
        end
    end

    // Outputs decoded from registered state only; lanes past LEN read 0x00.
    always_comb begin
        i_tready   = (state_q == c_ST_RECV);
        o_tvalid   = (state_q == c_ST_SEND);
        o_busy     = (state_q == c_ST_SEND);
        o_tlast    = (state_q == c_ST_SEND) && (w_final_beat || w_pkt_bnd);
        o_done_cnt = done_cnt_q;
        o_tdata    = '0;
        o_tkeep    = '0;
        for (int j = 0; j < c_NB; j++) begin
            logic [30:0] n;
            n = {1'b0, k_q} + 31'(j);
            if ((state_q == c_ST_SEND) && (n < {1'b0, len_q})) begin
                o_tkeep[j]       = 1'b1;
                o_tdata[j*8 +: 8] = pattern_byte(mode_q, n[7:0]);
            end
        end
    end

endmodule
`default_nettype wire
